// File: rtl/ptw_pkg.sv
// ============================================================================
// ptw_pkg -- shared state encoding, PTE layout and TLB flag order for the walker
// Rev 1.0
// ============================================================================
`default_nettype none

package ptw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_L1_REQ  = 3'd1,
    ST_L1_WAIT = 3'd2,
    ST_L0_REQ  = 3'd3,
    ST_L0_WAIT = 3'd4,
    ST_FILL    = 3'd5,
    ST_FAULT   = 3'd6,
    ST_DRAIN   = 3'd7
  } ptw_state_e;

  localparam int C_PTE_V       = 0;
  localparam int C_PTE_R       = 1;
  localparam int C_PTE_W       = 2;
  localparam int C_PTE_X       = 3;
  localparam int C_PTE_U       = 4;
  localparam int C_PTE_G       = 5;
  localparam int C_PTE_PPN_LSB = 10;

  // Width of one VPN index segment (and of the superpage alignment field)
  localparam int C_VPN_SEG_W = 10;

  localparam logic [1:0] C_CAUSE_INVALID    = 2'd0;
  localparam logic [1:0] C_CAUSE_NONLEAF    = 2'd1;
  localparam logic [1:0] C_CAUSE_ACCESS     = 2'd2;
  localparam logic [1:0] C_CAUSE_MISALIGNED = 2'd3;

  localparam int C_FLAG_R = 0;
  localparam int C_FLAG_W = 1;
  localparam int C_FLAG_X = 2;
  localparam int C_FLAG_U = 3;

  function automatic logic [3:0] pte_flags(input logic [31:0] pte);
    logic [3:0] f;
    f           = '0;
    f[C_FLAG_R] = pte[C_PTE_R];
    f[C_FLAG_W] = pte[C_PTE_W];
    f[C_FLAG_X] = pte[C_PTE_X];
    f[C_FLAG_U] = pte[C_PTE_U];
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ptw_pte_decode.sv
// ============================================================================
// ptw_pte_decode -- combinational classification and field extraction of a PTE
// Rev 1.0
// ============================================================================
`default_nettype none

module ptw_pte_decode
  import ptw_pkg::*;
#(
  parameter int PPN_WIDTH = 20
) (
  input  logic [31:0]          pte,
  output logic                 is_invalid,
  output logic                 is_leaf,
  output logic [3:0]           flags,
  output logic                 g,
  output logic [PPN_WIDTH-1:0] ppn
);

  logic w_unused_pte;

  // W without R is a reserved encoding and is treated like V=0
  assign is_invalid = !pte[C_PTE_V] || (pte[C_PTE_W] && !pte[C_PTE_R]);
  assign is_leaf    = pte[C_PTE_R] || pte[C_PTE_X];
  assign flags      = pte_flags(pte);
  assign g          = pte[C_PTE_G];
  assign ppn        = pte[PPN_WIDTH+C_PTE_PPN_LSB-1:C_PTE_PPN_LSB];

  generate
    if (PPN_WIDTH + C_PTE_PPN_LSB < 32) begin : g_pte_hi_spare
      assign w_unused_pte = ^{pte[31:PPN_WIDTH+C_PTE_PPN_LSB], pte[9:6]};
    end else begin : g_pte_hi_full
      assign w_unused_pte = ^pte[9:6];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ptw_walker.sv
// ============================================================================
// ptw_walker -- two-level Sv32-style page-table walker producing TLB fills/faults
// Rev 1.0
// ============================================================================
`default_nettype none

module ptw_walker
  import ptw_pkg::*;
#(
  parameter int VPN_WIDTH  = 20,
  parameter int PPN_WIDTH  = 20,
  parameter int ASID_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [VPN_WIDTH-1:0]  miss_vpn,
  input  logic [ASID_WIDTH-1:0] miss_asid,
  input  logic [PPN_WIDTH-1:0]  ptbr_ppn,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [PPN_WIDTH+11:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_data,
  input  logic                  mem_resp_err,
  output logic                  tlb_write_en,
  output logic [VPN_WIDTH-1:0]  tlb_write_vpn,
  output logic [PPN_WIDTH-1:0]  tlb_write_ppn,
  output logic [ASID_WIDTH-1:0] tlb_write_asid,
  output logic [3:0]            tlb_write_flags,
  output logic                  tlb_write_global,
  output logic                  fault_valid,
  output logic [VPN_WIDTH-1:0]  fault_vpn,
  output logic [1:0]            fault_cause,
  output logic                  busy
);

  ptw_state_e            r_state;
  ptw_state_e            w_state_nxt;
  logic [VPN_WIDTH-1:0]  r_vpn;
  logic [ASID_WIDTH-1:0] r_asid;
  logic [PPN_WIDTH-1:0]  r_ptbr;
  logic [PPN_WIDTH-1:0]  r_ptr_ppn;
  logic                  r_l1_g;

  logic                  r_tlb_write_en;
  logic [VPN_WIDTH-1:0]  r_tlb_write_vpn;
  logic [PPN_WIDTH-1:0]  r_tlb_write_ppn;
  logic [ASID_WIDTH-1:0] r_tlb_write_asid;
  logic [3:0]            r_tlb_write_flags;
  logic                  r_tlb_write_global;
  logic                  r_fault_valid;
  logic [VPN_WIDTH-1:0]  r_fault_vpn;
  logic [1:0]            r_fault_cause;

  logic                  w_pte_invalid;
  logic                  w_pte_leaf;
  logic [3:0]            w_pte_flags;
  logic                  w_pte_g;
  logic [PPN_WIDTH-1:0]  w_pte_ppn;
  logic                  w_pte_misaligned;

  logic                  w_accept;
  logic                  w_latch_ptr;
  logic                  w_fill;
  logic                  w_fault;
  logic [1:0]            w_cause;
  logic [PPN_WIDTH-1:0]  w_fill_ppn;

  ptw_pte_decode #(
    .PPN_WIDTH (PPN_WIDTH)
  ) u_pte_decode (
    .pte        (mem_resp_data),
    .is_invalid (w_pte_invalid),
    .is_leaf    (w_pte_leaf),
    .flags      (w_pte_flags),
    .g          (w_pte_g),
    .ppn        (w_pte_ppn)
  );

  assign w_pte_misaligned = (w_pte_ppn[C_VPN_SEG_W-1:0] != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_latch_ptr = 1'b0;
    w_fill      = 1'b0;
    w_fault     = 1'b0;
    w_cause     = C_CAUSE_INVALID;
    w_fill_ppn  = w_pte_ppn;

    case (r_state)
      ST_IDLE: begin
        if (miss_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_L1_REQ;
        end
      end

      ST_L1_REQ: begin
        if (flush)              w_state_nxt = ST_IDLE;
        else if (mem_req_ready) w_state_nxt = ST_L1_WAIT;
      end

      ST_L1_WAIT: begin
        // A response coinciding with the flush retires the request outright
        if (flush) begin
          w_state_nxt = mem_resp_valid ? ST_IDLE : ST_DRAIN;
        end else if (mem_resp_valid) begin
          if (mem_resp_err) begin
            w_fault = 1'b1;
            w_cause = C_CAUSE_ACCESS;
          end else if (w_pte_invalid) begin
            w_fault = 1'b1;
            w_cause = C_CAUSE_INVALID;
          end else if (w_pte_leaf) begin
            if (w_pte_misaligned) begin
              w_fault = 1'b1;
              w_cause = C_CAUSE_MISALIGNED;
            end else begin
              w_fill     = 1'b1;
              w_fill_ppn = {w_pte_ppn[PPN_WIDTH-1:C_VPN_SEG_W], r_vpn[C_VPN_SEG_W-1:0]};
            end
          end else begin
            w_latch_ptr = 1'b1;
            w_state_nxt = ST_L0_REQ;
          end
        end
      end

      ST_L0_REQ: begin
        if (flush)              w_state_nxt = ST_IDLE;
        else if (mem_req_ready) w_state_nxt = ST_L0_WAIT;
      end

      ST_L0_WAIT: begin
        if (flush) begin
          w_state_nxt = mem_resp_valid ? ST_IDLE : ST_DRAIN;
        end else if (mem_resp_valid) begin
          w_fault = 1'b1;
          if (mem_resp_err)       w_cause = C_CAUSE_ACCESS;
          else if (w_pte_invalid) w_cause = C_CAUSE_INVALID;
          else if (!w_pte_leaf)   w_cause = C_CAUSE_NONLEAF;
          else begin
            w_fault = 1'b0;
            w_fill  = 1'b1;
          end
        end
      end

      ST_FILL:  w_state_nxt = ST_IDLE;
      ST_FAULT: w_state_nxt = ST_IDLE;

      ST_DRAIN: begin
        if (mem_resp_valid) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_fill)  w_state_nxt = ST_FILL;
    if (w_fault) w_state_nxt = ST_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= ST_IDLE;
      r_vpn              <= '0;
      r_asid             <= '0;
      r_ptbr             <= '0;
      r_ptr_ppn          <= '0;
      r_l1_g             <= 1'b0;
      r_tlb_write_en     <= 1'b0;
      r_tlb_write_vpn    <= '0;
      r_tlb_write_ppn    <= '0;
      r_tlb_write_asid   <= '0;
      r_tlb_write_flags  <= '0;
      r_tlb_write_global <= 1'b0;
      r_fault_valid      <= 1'b0;
      r_fault_vpn        <= '0;
      r_fault_cause      <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_tlb_write_en <= w_fill;
      r_fault_valid  <= w_fault;

      if (w_accept) begin
        r_vpn  <= miss_vpn;
        r_asid <= miss_asid;
        r_ptbr <= ptbr_ppn;
        r_l1_g <= 1'b0;
      end

      if (w_latch_ptr) begin
        r_ptr_ppn <= w_pte_ppn;
        r_l1_g    <= w_pte_g;
      end

      if (w_fill) begin
        r_tlb_write_vpn    <= r_vpn;
        r_tlb_write_ppn    <= w_fill_ppn;
        r_tlb_write_asid   <= r_asid;
        r_tlb_write_flags  <= w_pte_flags;
        r_tlb_write_global <= w_pte_g | r_l1_g;
      end

      if (w_fault) begin
        r_fault_vpn   <= r_vpn;
        r_fault_cause <= w_cause;
      end
    end
  end

  // Flush withdraws a pending request in the same cycle it is raised
  assign mem_req_valid = ((r_state == ST_L1_REQ) || (r_state == ST_L0_REQ)) && !flush;
  assign mem_req_addr  = (r_state == ST_L0_REQ)
                       ? {r_ptr_ppn, r_vpn[C_VPN_SEG_W-1:0], 2'b00}
                       : {r_ptbr, r_vpn[VPN_WIDTH-1:C_VPN_SEG_W], 2'b00};

  assign miss_ready       = (r_state == ST_IDLE);
  assign busy             = (r_state != ST_IDLE);
  assign tlb_write_en     = r_tlb_write_en;
  assign tlb_write_vpn    = r_tlb_write_vpn;
  assign tlb_write_ppn    = r_tlb_write_ppn;
  assign tlb_write_asid   = r_tlb_write_asid;
  assign tlb_write_flags  = r_tlb_write_flags;
  assign tlb_write_global = r_tlb_write_global;
  assign fault_valid      = r_fault_valid;
  assign fault_vpn        = r_fault_vpn;
  assign fault_cause      = r_fault_cause;

endmodule

`default_nettype wire

// File: tb/tb_ptw_walker.sv
// ============================================================================
// tb_ptw_walker -- table, hand-sequence and randomized checks of ptw_walker
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ptw_walker;

  logic        clk;
  logic        rst_n;
  logic        miss_valid;
  logic        miss_ready;
  logic [19:0] miss_vpn;
  logic [7:0]  miss_asid;
  logic [19:0] ptbr_ppn;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        tlb_write_en;
  logic [19:0] tlb_write_vpn;
  logic [19:0] tlb_write_ppn;
  logic [7:0]  tlb_write_asid;
  logic [3:0]  tlb_write_flags;
  logic        tlb_write_global;
  logic        fault_valid;
  logic [19:0] fault_vpn;
  logic [1:0]  fault_cause;
  logic        busy;

  int tests = 0;
  int fails = 0;

  ptw_walker #(
    .VPN_WIDTH  (20),
    .PPN_WIDTH  (20),
    .ASID_WIDTH (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_valid       (miss_valid),
    .miss_ready       (miss_ready),
    .miss_vpn         (miss_vpn),
    .miss_asid        (miss_asid),
    .ptbr_ppn         (ptbr_ppn),
    .flush            (flush),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_addr     (mem_req_addr),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_data    (mem_resp_data),
    .mem_resp_err     (mem_resp_err),
    .tlb_write_en     (tlb_write_en),
    .tlb_write_vpn    (tlb_write_vpn),
    .tlb_write_ppn    (tlb_write_ppn),
    .tlb_write_asid   (tlb_write_asid),
    .tlb_write_flags  (tlb_write_flags),
    .tlb_write_global (tlb_write_global),
    .fault_valid      (fault_valid),
    .fault_vpn        (fault_vpn),
    .fault_cause      (fault_cause),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [19:0] ptbr;
    logic [19:0] vpn;
    logic [7:0]  asid;
    logic [31:0] p1;
    logic        e1;
    logic [31:0] p0;
    logic        e0;
    int          rw;
    int          sw;
    logic        exp_fault;
    int          exp_levels;
    logic [19:0] exp_ppn;
    logic [3:0]  exp_flags;
    logic        exp_glob;
    logic [1:0]  exp_cause;
    int          exp_lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [19:0] ptbr, input logic [19:0] vpn, input logic [7:0] asid,
                              input logic [31:0] p1, input logic e1, input logic [31:0] p0, input logic e0,
                              input int rw, input int sw, input logic f, input int lv,
                              input logic [19:0] ppn, input logic [3:0] fl, input logic g,
                              input logic [1:0] c, input int lat);
    vec_t v;
    v.ptbr = ptbr; v.vpn = vpn; v.asid = asid; v.p1 = p1; v.e1 = e1; v.p0 = p0; v.e0 = e0;
    v.rw = rw; v.sw = sw; v.exp_fault = f; v.exp_levels = lv; v.exp_ppn = ppn;
    v.exp_flags = fl; v.exp_glob = g; v.exp_cause = c; v.exp_lat = lat;
    return v;
  endfunction

  // Reference model: interprets the PTEs numerically, level by level
  function automatic int bitn(input logic [31:0] p, input int n);
    return int'((p >> n) & 32'd1);
  endfunction

  function automatic bit pte_invalid(input logic [31:0] p);
    return (bitn(p, 0) == 0) || (bitn(p, 2) == 1 && bitn(p, 1) == 0);
  endfunction

  function automatic bit pte_leaf(input logic [31:0] p);
    return (bitn(p, 1) == 1) || (bitn(p, 3) == 1);
  endfunction

  function automatic int pte_fl(input logic [31:0] p);
    return bitn(p, 1) + 2 * bitn(p, 2) + 4 * bitn(p, 3) + 8 * bitn(p, 4);
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r;
    int ppn1, ppn0, vpn0, ppn, fl, g, cause, lv;
    bit   f;
    r = v;
    ppn1 = int'((v.p1 >> 10) & 32'hFFFFF);
    ppn0 = int'((v.p0 >> 10) & 32'hFFFFF);
    vpn0 = int'(32'(v.vpn) % 32'd1024);
    f = 1; lv = 1; ppn = 0; fl = 0; g = 0; cause = 0;
    if (v.e1)                 cause = 2;
    else if (pte_invalid(v.p1)) cause = 0;
    else if (pte_leaf(v.p1)) begin
      if (ppn1 % 1024 != 0) cause = 3;
      else begin
        f = 0; ppn = ppn1 + vpn0; fl = pte_fl(v.p1); g = bitn(v.p1, 5);
      end
    end else begin
      lv = 2;
      if (v.e0)                   cause = 2;
      else if (pte_invalid(v.p0)) cause = 0;
      else if (!pte_leaf(v.p0))   cause = 1;
      else begin
        f = 0; ppn = ppn0; fl = pte_fl(v.p0);
        g = (bitn(v.p0, 5) == 1 || bitn(v.p1, 5) == 1) ? 1 : 0;
      end
    end
    r.exp_fault  = f;
    r.exp_levels = lv;
    r.exp_ppn    = 20'(ppn);
    r.exp_flags  = 4'(fl);
    r.exp_glob   = g[0];
    r.exp_cause  = 2'(cause);
    r.exp_lat    = 2 * lv + 1 + lv * (v.rw + v.sw);
    return r;
  endfunction

  task automatic start_miss(input logic [19:0] ptbr, input logic [19:0] vpn, input logic [7:0] asid);
    @(negedge clk);
    miss_valid = 1'b1; miss_vpn = vpn; miss_asid = asid; ptbr_ppn = ptbr;
    @(negedge clk);
    miss_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          cyc;
    int          nreq;
    int          n;
    logic [31:0] eaddr;
    @(negedge clk);
    chk({tag, "_miss_ready"}, miss_ready, 1'b1);
    miss_valid = 1'b1; miss_vpn = v.vpn; miss_asid = v.asid; ptbr_ppn = v.ptbr;
    @(negedge clk);
    miss_valid = 1'b0;
    miss_vpn   = 20'($urandom);
    ptbr_ppn   = 20'($urandom);
    cyc  = 1;
    nreq = 0;
    for (int lvl = 1; lvl <= 2; lvl++) begin
      n = 0;
      while (!mem_req_valid && !tlb_write_en && !fault_valid && n < 20) begin
        @(negedge clk); cyc++; n++;
      end
      if (!mem_req_valid) break;
      nreq++;
      if (lvl == 1)
        eaddr = 32'(v.ptbr) * 32'd4096 + (32'(v.vpn) / 32'd1024) * 32'd4;
      else
        eaddr = ((32'(v.p1) / 32'd1024) % 32'd1048576) * 32'd4096 + (32'(v.vpn) % 32'd1024) * 32'd4;
      chk({tag, "_req_addr"}, mem_req_addr, eaddr);
      for (int k = 0; k < v.rw; k++) begin
        @(negedge clk); cyc++;
        chk({tag, "_req_hold"}, {mem_req_valid, mem_req_addr}, {1'b1, eaddr});
      end
      mem_req_ready = 1'b1;
      @(negedge clk); cyc++;
      mem_req_ready = 1'b0;
      for (int k = 0; k < v.sw; k++) begin
        @(negedge clk); cyc++;
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = (lvl == 1) ? v.p1 : v.p0;
      mem_resp_err   = (lvl == 1) ? v.e1 : v.e0;
      @(negedge clk); cyc++;
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
      mem_resp_err   = 1'b0;
    end
    n = 0;
    while (!tlb_write_en && !fault_valid && n < 20) begin
      @(negedge clk); cyc++; n++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(v.exp_lat));
    chk({tag, "_levels"}, 64'(nreq), 64'(v.exp_levels));
    chk({tag, "_pulse"}, {tlb_write_en, fault_valid}, v.exp_fault ? 2'b01 : 2'b10);
    if (!v.exp_fault) begin
      chk({tag, "_ppn"}, tlb_write_ppn, v.exp_ppn);
      chk({tag, "_flags"}, tlb_write_flags, v.exp_flags);
      chk({tag, "_global"}, tlb_write_global, v.exp_glob);
      chk({tag, "_asid"}, tlb_write_asid, v.asid);
      chk({tag, "_wvpn"}, tlb_write_vpn, v.vpn);
    end else begin
      chk({tag, "_cause"}, fault_cause, v.exp_cause);
      chk({tag, "_fvpn"}, fault_vpn, v.vpn);
    end
    @(negedge clk);
    chk({tag, "_after"}, {miss_ready, busy, tlb_write_en, fault_valid}, 4'b1000);
  endtask

  initial begin
    vec_t rv;
    rst_n = 1'b0; miss_valid = 1'b0; miss_vpn = '0; miss_asid = '0; ptbr_ppn = '0;
    flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;

    //            ptbr      vpn       asid   p1            e1    p0            e0    rw sw f     lv ppn       flags    g     cause lat
    tbl[0]  = mk(20'h00100, 20'h12345, 8'h07, 32'h00800001, 1'b0, 32'h2AF37817, 1'b0, 0, 0, 1'b0, 2, 20'hABCDE, 4'b1011, 1'b0, 2'd0, 5);
    tbl[1]  = mk(20'h00100, 20'h12345, 8'h07, 32'h1000000B, 1'b0, 32'h0,        1'b0, 0, 0, 1'b0, 1, 20'h40345, 4'b0101, 1'b0, 2'd0, 3);
    tbl[2]  = mk(20'h00100, 20'h12345, 8'h07, 32'h1000040B, 1'b0, 32'h0,        1'b0, 0, 0, 1'b1, 1, 20'h0,     4'b0000, 1'b0, 2'd3, 3);
    tbl[3]  = mk(20'h00100, 20'h12345, 8'h07, 32'h00800001, 1'b0, 32'h2AF37817, 1'b1, 0, 0, 1'b1, 2, 20'h0,     4'b0000, 1'b0, 2'd2, 5);
    tbl[4]  = mk(20'h00100, 20'h12345, 8'h07, 32'h00800001, 1'b0, 32'h00000401, 1'b0, 0, 0, 1'b1, 2, 20'h0,     4'b0000, 1'b0, 2'd1, 5);
    tbl[5]  = mk(20'hFFFFF, 20'hFFFFF, 8'hFF, 32'h00000000, 1'b0, 32'h0,        1'b0, 0, 0, 1'b1, 1, 20'h0,     4'b0000, 1'b0, 2'd0, 3);
    tbl[6]  = mk(20'h00100, 20'h12345, 8'h07, 32'h00800005, 1'b0, 32'h0,        1'b0, 0, 0, 1'b1, 1, 20'h0,     4'b0000, 1'b0, 2'd0, 3);
    tbl[7]  = mk(20'h00100, 20'h12345, 8'h07, 32'h00800021, 1'b0, 32'h2AF37817, 1'b0, 0, 0, 1'b0, 2, 20'hABCDE, 4'b1011, 1'b1, 2'd0, 5);
    tbl[8]  = mk(20'h00100, 20'h12345, 8'h07, 32'h00800001, 1'b1, 32'h0,        1'b0, 0, 0, 1'b1, 1, 20'h0,     4'b0000, 1'b0, 2'd2, 3);
    tbl[9]  = mk(20'h00ABC, 20'h12345, 8'h31, 32'h1000000B, 1'b0, 32'h0,        1'b0, 5, 0, 1'b0, 1, 20'h40345, 4'b0101, 1'b0, 2'd0, 8);
    tbl[10] = mk(20'h00100, 20'h003FF, 8'h07, 32'h00800001, 1'b0, 32'h2AF37817, 1'b0, 1, 2, 1'b0, 2, 20'hABCDE, 4'b1011, 1'b0, 2'd0, 11);

    repeat (3) @(negedge clk);
    chk("reset_state", {miss_ready, busy, mem_req_valid, tlb_write_en, fault_valid},
        5'b10000);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Flush in L1_WAIT, response three cycles later is drained silently
    start_miss(20'h00100, 20'h12345, 8'h07);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("drain_busy", {busy, miss_ready, mem_req_valid}, 3'b100);
    @(negedge clk);
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1000000B;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("drain_done", {miss_ready, tlb_write_en, fault_valid}, 3'b100);
    @(negedge clk);
    chk("drain_quiet", {miss_ready, tlb_write_en, fault_valid}, 3'b100);
    run_vec(tbl[0], "after_drain");

    // Flush in L1_REQ withdraws the request even with ready high
    start_miss(20'h00100, 20'h12345, 8'h07);
    mem_req_ready = 1'b1; flush = 1'b1;
    #1;
    chk("flush_req_withdrawn", mem_req_valid, 1'b0);
    @(negedge clk);
    mem_req_ready = 1'b0; flush = 1'b0;
    chk("flush_req_idle", {miss_ready, busy}, 2'b10);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1000000B;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("idle_resp_ignored", {miss_ready, busy, tlb_write_en, fault_valid}, 4'b1000);

    // Flush in L0_WAIT together with the response goes straight to IDLE
    start_miss(20'h00100, 20'h12345, 8'h07);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h00800001;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h2AF37817; flush = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0; flush = 1'b0;
    chk("flush_resp_same", {miss_ready, busy, tlb_write_en, fault_valid}, 4'b1000);

    // Flush during FILL does not suppress the pulse
    start_miss(20'h00100, 20'h12345, 8'h07);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h1000000B;
    @(negedge clk);
    mem_resp_valid = 1'b0; flush = 1'b1;
    chk("fill_flush_pulse", {tlb_write_en, tlb_write_ppn}, {1'b1, 20'h40345});
    @(negedge clk);
    flush = 1'b0;
    chk("fill_flush_idle", {miss_ready, tlb_write_en}, 2'b10);

    // Asynchronous reset in the middle of a walk
    start_miss(20'h00100, 20'h12345, 8'h07);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_walk", {busy, miss_ready, mem_req_valid, tlb_write_en, fault_valid}, 5'b01000);
    chk("reset_mid_ppn", tlb_write_ppn, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      int sel;
      rv.ptbr = 20'($urandom);
      rv.vpn  = 20'($urandom);
      rv.asid = 8'($urandom);
      for (int lv = 0; lv < 2; lv++) begin
        logic [31:0] p;
        p = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 4) p[3:1] = 3'b000;
        if (sel >= 4 && sel < 7) p[19:10] = 10'h000;
        p[0] = (sel != 9);
        if (lv == 0) rv.p1 = p; else rv.p0 = p;
      end
      rv.e1 = ($urandom_range(0, 9) == 0);
      rv.e0 = ($urandom_range(0, 9) == 0);
      rv.rw = $urandom_range(0, 2);
      rv.sw = $urandom_range(0, 2);
      run_vec(model(rv), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
